hidden_wires_arbiter: RTL and testbench
=======================================

HIDDEN_WIRES_ARBITER -- requirements
Module: hidden_wires_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester last beat of burst.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_W  per-requester data, packed as req_addr.
REQ-010 SHALL have port req_ready  output  NUM_REQ  per-requester beat accepted (combinational).
REQ-011 SHALL have port hw_address  output  ADDR_W  registered shared-channel address.
REQ-012 SHALL have port hw_data  output  DATA_W  registered shared-channel data.
REQ-013 SHALL have port hw_enable  output  1  registered shared-channel beat valid.
REQ-014 SHALL have port hw_ready  input  1  downstream consumes beat when hw_enable and hw_ready both high.
REQ-015 SHALL have port grant_id  output  $clog2(NUM_REQ)  requester index of the beat on hw_address/hw_data.
REQ-016 SHALL have port locked  output  1  high while a burst owns the channel.

Function
REQ-017 Transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-018 Output register "can load" SHALL equal (!hw_enable || hw_ready).
REQ-019 At most one req_ready bit SHALL be high in any cycle; all SHALL be low when can-load is low.
REQ-020 State machine SHALL have two states: IDLE (no owner) and LOCK (owner = lock_id).
REQ-021 In IDLE with can-load high, the winner SHALL be the first i with req_valid[i] high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ; req_ready[winner] SHALL be high.
REQ-022 In LOCK, only lock_id SHALL be eligible; req_ready[lock_id] = req_valid[lock_id] && can-load; all other ready bits SHALL be low even if owner is idle.
REQ-023 On an accepted beat, hw_address, hw_data, grant_id SHALL load the winner's values and hw_enable SHALL be 1 at the next edge (latency 1 cycle).
REQ-024 When can-load is high and no beat is accepted, hw_enable SHALL go to 0 and hw_address, hw_data, grant_id SHALL hold.
REQ-025 When hw_enable=1 and hw_ready=0, hw_address, hw_data, grant_id, hw_enable SHALL hold unchanged.
REQ-026 Accepted beat with req_last=0 SHALL move to (or stay in) LOCK with lock_id = winner.
REQ-027 Accepted beat with req_last=1 SHALL move to IDLE and set rr_ptr = (winner+1) mod NUM_REQ.
REQ-028 rr_ptr SHALL change only per REQ-027; wrap-around from NUM_REQ-1 SHALL give 0.
REQ-029 locked SHALL equal (state == LOCK).
REQ-030 Back-to-back: with hw_ready=1 held high, one beat per cycle SHALL be sustained.
REQ-031 Simultaneous consume and load in one cycle SHALL replace the beat, with hw_enable staying 1.
REQ-032 req_valid of a non-winning requester SHALL NOT affect any state.

Reset
REQ-033 While rst=1 at an edge: hw_enable=0, hw_address=0, hw_data=0, grant_id=0, rr_ptr=0, state=IDLE, lock_id=0.
REQ-034 While rst is high, req_ready SHALL be all zeros.
REQ-035 Reset mid-burst SHALL abandon the burst; the pending hw_enable beat SHALL be dropped.

Verification
REQ-036 Reset, then req_valid=4'b1111, all last=1, hw_ready=1 -> grants in order 0,1,2,3,0; hw_enable high every cycle from the 2nd cycle on.
REQ-037 Req 2 sends 3-beat burst (last on beat 3) while req 0 and 1 are held valid -> grant_id 2,2,2 then 0, then 1; locked=1 for beats 1-2.
REQ-038 hw_enable=1, hw_ready=0 for 3 cycles with req 1 valid -> hw_address/hw_data stable, req_ready=0; beat moves 1 cycle after hw_ready=1.
REQ-039 Only req 3 valid (rr_ptr=0), last=1 -> grant 3, rr_ptr becomes 0 (wrap); next winner search starts at 0.
REQ-040 rst asserted during LOCK owned by req 1 -> next cycle hw_enable=0, locked=0, rr_ptr=0; req 0 wins first after release.
REQ-041 Random valid/last/hw_ready for 10k cycles -> scoreboard: no beat lost or duplicated, at most one ready, burst beats contiguous per requester.

Source files
------------

// File: rtl/hidden_wires_arbiter.sv
// Round-robin arbiter that multiplexes NUM_REQ burst requesters onto one registered
// shared channel; a burst keeps the channel locked to its requester until its last beat.
module hidden_wires_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          hw_address,
  output logic [DATA_W-1:0]          hw_data,
  output logic                       hw_enable,
  input  logic                       hw_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   lock_id_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic [ADDR_W-1:0]  hw_address_q;
  logic [DATA_W-1:0]  hw_data_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic               hw_enable_q;

  logic               can_load_s;
  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [IDX_W-1:0]   acc_idx_s;
  logic               acc_s;
  logic               acc_last_s;

  // (base + offset) modulo NUM_REQ, with offset in 0..NUM_REQ
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    return IDX_W'(sum);
  endfunction

  assign can_load_s = !hw_enable_q || hw_ready;

  // Round-robin search for the first valid requester starting at rr_ptr
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found_s && req_valid[rr_index(rr_ptr_q, k)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_index(rr_ptr_q, k);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // One-hot ready: the lock owner only while locked, else the round-robin winner
  always_comb begin
    ready_s = '0;
    if (rst || !can_load_s) begin
      ready_s = '0;
    end else if (state_q == S_LOCK) begin
      ready_s[lock_id_q] = req_valid[lock_id_q];
    end else if (win_found_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign acc_idx_s  = (state_q == S_LOCK) ? lock_id_q : win_idx_s;
  assign acc_s      = |(req_valid & ready_s);
  assign acc_last_s = req_last[acc_idx_s];
  assign rr_ptr_d   = rr_index(acc_idx_s, 1);

  // Arbitration state and the registered shared-channel beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      hw_address_q <= '0;
      hw_data_q    <= '0;
      grant_id_q   <= '0;
      hw_enable_q  <= 1'b0;
    end else begin
      if (acc_s) begin
        hw_address_q <= req_addr[int'(acc_idx_s)*ADDR_W +: ADDR_W];
        hw_data_q    <= req_data[int'(acc_idx_s)*DATA_W +: DATA_W];
        grant_id_q   <= acc_idx_s;
        hw_enable_q  <= 1'b1;
        if (acc_last_s) begin
          state_q  <= S_IDLE;
          rr_ptr_q <= rr_ptr_d;
        end else begin
          state_q   <= S_LOCK;
          lock_id_q <= acc_idx_s;
        end
      end else if (can_load_s) begin
        hw_enable_q <= 1'b0;
      end else begin
        hw_enable_q <= hw_enable_q;
      end
    end
  end

  assign req_ready  = ready_s;
  assign hw_address = hw_address_q;
  assign hw_data    = hw_data_q;
  assign hw_enable  = hw_enable_q;
  assign grant_id   = grant_id_q;
  assign locked     = (state_q == S_LOCK);

endmodule

// File: tb/tb_hidden_wires_arbiter.sv
// Scoreboard bench for hidden_wires_arbiter: a rule-level model predicts ready bits and
// accepted beats; a negedge monitor pops and compares every beat the channel delivers.
module tb_hidden_wires_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 64;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_last = '0;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        hw_address;
  logic [DW-1:0]        hw_data;
  logic                 hw_enable;
  logic                 hw_ready = 1'b0;
  logic [1:0]           grant_id;
  logic                 locked;

  typedef struct {
    int          idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb_q[$];
  int    seen_q[$];
  int    checks = 0;
  int    failures = 0;

  // reference model state
  bit m_en = 1'b0;
  bit m_locked = 1'b0;
  int m_owner = 0;
  int m_rr = 0;

  hidden_wires_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .hw_address(hw_address), .hw_data(hw_data), .hw_enable(hw_enable),
    .hw_ready(hw_ready), .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every consumed beat must be the oldest predicted beat
  always @(negedge clk) begin
    beat_t b;
    if (!rst && hw_enable === 1'b1 && hw_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got grant %0d with nothing expected at %0t", grant_id, $time);
      end else begin
        b = sb_q.pop_front();
        check_eq("beat_grant", 64'(grant_id), 64'(b.idx));
        check_eq("beat_addr", hw_address, b.addr);
        check_eq("beat_data", 64'(hw_data), 64'(b.data));
        seen_q.push_back(int'(grant_id));
      end
    end
  end

  task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic hr);
    logic [NREQ-1:0] exp_rdy;
    int  win;
    bit  can_load;
    @(posedge clk);
    #1;
    rst = r;
    req_valid = v;
    req_last = l;
    hw_ready = hr;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = {$urandom, $urandom};
      req_data[i*DW +: DW] = $urandom;
    end
    #1;
    can_load = !m_en || hr;
    win = -1;
    if (!r && can_load) begin
      if (m_locked) begin
        if (v[m_owner]) win = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && v[(m_rr + k) % NREQ]) win = (m_rr + k) % NREQ;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("hw_enable", 64'(hw_enable), 64'(m_en));
    check_eq("locked", 64'(locked), 64'(m_locked));
    if (r) begin
      sb_q.delete();
      m_en = 1'b0;
      m_locked = 1'b0;
      m_owner = 0;
      m_rr = 0;
    end else if (win >= 0) begin
      beat_t b;
      b.idx = win;
      b.addr = req_addr[win*AW +: AW];
      b.data = req_data[win*DW +: DW];
      sb_q.push_back(b);
      m_en = 1'b1;
      if (l[win]) begin
        m_locked = 1'b0;
        m_rr = (win + 1) % NREQ;
      end else begin
        m_locked = 1'b1;
        m_owner = win;
      end
    end else if (can_load) begin
      m_en = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b0000, 1'b1);
  endtask

  task automatic reset_and_clear();
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    seen_q.delete();
  endtask

  task automatic check_seen(input string name, input int e[$]);
    for (int i = 0; i < e.size(); i++) begin
      if (i >= seen_q.size()) begin
        checks++;
        failures++;
        $display("FAIL %s: only %0d beats seen, expected grant %0d at position %0d", name, seen_q.size(), e[i], i);
      end else begin
        check_eq(name, 64'(seen_q[i]), 64'(e[i]));
      end
    end
  endtask

  initial begin
    // all requesters valid, single-beat bursts: strict rotation
    reset_and_clear();
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1111, 4'b1111, 1'b1);
    drain();
    check_seen("rotation", '{0, 1, 2, 3, 0});

    // 3-beat burst from requester 2 holds off 0 and 1
    reset_and_clear();
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0111, 4'b0000, 1'b1);
    step(1'b0, 4'b0111, 4'b0100, 1'b1);
    step(1'b0, 4'b0011, 4'b0011, 1'b1);
    step(1'b0, 4'b0011, 4'b0011, 1'b1);
    drain();
    check_seen("burst", '{2, 2, 2, 0, 1});

    // downstream back-pressure holds the beat
    reset_and_clear();
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0010, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    drain();
    check_seen("backpressure", '{1, 1});

    // pointer wrap after the last requester wins
    reset_and_clear();
    step(1'b0, 4'b1000, 4'b1000, 1'b1);
    step(1'b0, 4'b1001, 4'b1111, 1'b1);
    drain();
    check_seen("wrap", '{3, 0});

    // reset in the middle of a locked burst drops the pending beat
    reset_and_clear();
    step(1'b0, 4'b0010, 4'b0000, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 1'b0);
    reset_and_clear();
    step(1'b0, 4'b1111, 4'b1111, 1'b1);
    drain();
    check_seen("reset_mid_burst", '{0});

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      logic [NREQ-1:0] v;
      logic [NREQ-1:0] l;
      v = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) l[i] = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 499) == 0), v, l, ($urandom_range(0, 3) != 0));
    end
    drain();
    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
